// File: rtl/hc194_shift.sv
// Universal bidirectional shift register in the style of the 74HC194: hold, shift right,
// shift left or parallel load, selected by {S1,S0}, with synchronous active-high reset.
module hc194_shift #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             CP,
   input  logic             RD,
   input  logic             S1,
   input  logic             S0,
   input  logic             DSR,
   input  logic             DSL,
   input  logic [WIDTH-1:0] P,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] QN,
   output logic             SOR,
   output logic             SOL
);

   logic [WIDTH-1:0] q_d;
   logic [WIDTH-1:0] q_q;

   always_comb begin
      q_d = q_q;
      case ({S1, S0})
         2'b00:   q_d = q_q;
         2'b01:   q_d = {q_q[WIDTH-2:0], DSR};
         2'b10:   q_d = {DSL, q_q[WIDTH-1:1]};
         2'b11:   q_d = P;
         // An unknown mode must poison the state rather than pick a legal operation.
         default: q_d = 'x;
      endcase
   end

   always_ff @(posedge CP) begin
      if (RD) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign Q   = q_q;
   assign QN  = ~q_q;
   assign SOR = q_q[WIDTH-1];
   assign SOL = q_q[0];

endmodule

// File: doc/hc194_shift.md
HC194_SHIFT -- requirements
Module: hc194_shift

Interface
REQ-001 The block SHALL be clocked by a single clock and SHALL use a synchronous, active-high reset.
REQ-002 The block SHALL have one parameter: WIDTH, default 4, register width in bits; legal range 2..16.
REQ-003 Port CP  input  1  rising-edge clock; the only clock.
REQ-004 Port RD  input  1  synchronous active-high reset, sampled on the rising CP edge.
REQ-005 Port S1  input  1  mode select, high bit.
REQ-006 Port S0  input  1  mode select, low bit.
REQ-007 Port DSR  input  1  serial data in for shift-right; enters Q[0].
REQ-008 Port DSL  input  1  serial data in for shift-left; enters Q[WIDTH-1].
REQ-009 Port P  input  WIDTH  parallel load data.
REQ-010 Port Q  output  WIDTH  registered state; Q[0] is stage A.
REQ-011 Port QN  output  WIDTH  bitwise complement of Q; combinational from Q only.
REQ-012 Port SOR  output  1  serial out, right end; equals Q[WIDTH-1].
REQ-013 Port SOL  output  1  serial out, left end; equals Q[0].

Function
REQ-014 State SHALL change only on the rising edge of CP, never on any other input edge.
REQ-015 Mode {S1,S0}=00 (HOLD): Q SHALL keep its value.
REQ-016 Mode 01 (SHIFT_R): next Q[0]=DSR and Q[i]=Q[i-1] for i=1..WIDTH-1; the old Q[WIDTH-1] is discarded.
REQ-017 Mode 10 (SHIFT_L): next Q[WIDTH-1]=DSL and Q[i]=Q[i+1] for i=0..WIDTH-2; the old Q[0] is discarded.
REQ-018 Mode 11 (LOAD): next Q SHALL equal P.
REQ-019 Latency SHALL be exactly one CP edge from sampled inputs to the Q update; no pipeline stages.
REQ-020 S1, S0, DSR, DSL and P SHALL be sampled only at the same rising edge that applies the operation.
REQ-021 Mode changes between edges SHALL have no effect on Q until the next rising edge.
REQ-022 QN SHALL equal ~Q at all times, including during reset.
REQ-023 SOR/SOL SHALL track Q, so cascading two instances gives a 2*WIDTH shifter with no extra delay:
- SOR feeds the next stage's DSR.
- SOL feeds the previous stage's DSL.
REQ-024 X or Z on any mode input SHALL NOT be resolved to a legal mode silently; simulation propagates X to Q.

Reset
REQ-025 When RD=1 at a rising CP edge, Q SHALL become all zeros; QN all ones; SOR=0; SOL=0.
REQ-026 RD SHALL have priority over every mode, including a simultaneous LOAD.
REQ-027 RD asserted mid-sequence (e.g. during a run of shifts) SHALL clear on that edge; data in flight is lost.
REQ-028 RD asserted between edges SHALL NOT change Q before the next rising CP edge.
REQ-029 Before the first reset edge, Q is undefined; no power-on value is guaranteed.
REQ-030 On the first edge after RD deasserts, the block SHALL execute the mode presented on that edge.

Verification (WIDTH=4)
REQ-031 Reset-over-load: RD=1, mode 11, P=1011, one edge -> Q=0000, QN=1111, SOR=0, SOL=0.
REQ-032 Load then hold: RD=0, mode 11, P=1010, one edge -> Q=1010; then mode 00 for 3 edges with P=0101 -> Q stays 1010.
REQ-033 Shift right:
- Stimulus: Q=0000; mode 01; DSR=1,1,0,1 over 4 edges.
- Required: Q = 0001, 0011, 0110, 1101 after each edge; SOR=1 after edge 4.
REQ-034 Shift left:
- Stimulus: load Q=1000; mode 10; DSL=0 for 4 edges.
- Required: Q = 0100, 0010, 0001, 0000; SOL=1 only after edge 3.
REQ-035 Reset mid-operation:
- Stimulus: shifting right with DSR=1 from Q=0000; RD=1 coincides with the 3rd edge.
- Required: Q=0000 after edge 3; shifting resumes on edge 4 after RD drops, giving Q=0001.
REQ-036 Cascade:
- Stimulus: two instances in series, load 0000 and 0000, DSR=1, mode 01 for 5 edges.
- Required: low instance Q=1111; high instance Q=0001.
